// File: rtl/queen_pkg.sv
// Shared definitions for the 12-queens solver and its verdict checker.
package queen_pkg;

    localparam int N = 12;
    localparam logic [3:0] MAX_IDX = 4'd11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RECV   = 3'd2,
        CHECK  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_RANGE  = 2'b01;
    localparam logic [1:0] ERR_PRE    = 2'b10;
    localparam logic [1:0] ERR_ATTACK = 2'b11;

    typedef logic [N-1:0][3:0] rows_t;

    // Magnitude of a difference, always larger minus smaller so nothing wraps.
    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/queen_col_check.sv
// Combinational legality test of a single column k against the columns before it.
module queen_col_check
    import queen_pkg::*;
(
    input  rows_t            rows,
    input  logic [3:0]       k,
    input  logic [N-1:0]     mask,
    input  logic [3:0]       pre_row,
    output logic             fail,
    output logic [1:0]       code
);

    logic [3:0] row_k;
    logic       attack;

    // Scan every earlier column for a shared row or diagonal.
    always_comb begin
        row_k  = rows[k];
        attack = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (4'(i) < k) begin
                if ((rows[i] == row_k) || (abs_diff(rows[i], row_k) == (k - 4'(i)))) begin
                    attack = 1'b1;
                end else begin
                    attack = attack;
                end
            end else begin
                attack = attack;
            end
        end
    end

    // Prioritised error code: range, then pre-placed mismatch, then attack.
    always_comb begin
        code = ERR_OK;
        if (row_k > MAX_IDX) begin
            code = ERR_RANGE;
        end else if (mask[k] && (row_k != pre_row)) begin
            code = ERR_PRE;
        end else if (attack) begin
            code = ERR_ATTACK;
        end else begin
            code = ERR_OK;
        end
        fail = (code != ERR_OK);
    end

endmodule

// File: rtl/queen_check.sv
// Collects pre-placed queens and a 12-column solution stream, then checks one column per cycle.
module queen_check
    import queen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] col,
    input  logic [3:0] row,
    input  logic       sol_valid,
    input  logic [3:0] sol_row,
    output logic       done,
    output logic       pass,
    output logic [1:0] err_code,
    output logic [3:0] err_col
);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   k_q, k_d;
    logic [N-1:0] mask_q, mask_d;
    rows_t        pre_q, pre_d;
    rows_t        rows_q, rows_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic [1:0]   err_code_q, err_code_d;
    logic [3:0]   err_col_q, err_col_d;

    logic         col_fail;
    logic [1:0]   col_code;

    queen_col_check u_col_check (
        .rows    (rows_q),
        .k       (k_q),
        .mask    (mask_q),
        .pre_row (pre_q[k_q]),
        .fail    (col_fail),
        .code    (col_code)
    );

    // Next-state and verdict logic; verdict outputs are only non-zero for the REPORT cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        mask_d     = mask_q;
        pre_d      = pre_q;
        rows_d     = rows_q;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        err_code_d = ERR_OK;
        err_col_d  = 4'd0;
        case (state_q)
            IDLE, LOAD: begin
                // Pre-placed beat is applied before any same-cycle solution beat.
                if (in_valid && (col <= MAX_IDX)) begin
                    if (state_q == IDLE) begin
                        mask_d = {N{1'b0}};
                    end else begin
                        mask_d = mask_q;
                    end
                    pre_d[col]  = row;
                    mask_d[col] = 1'b1;
                    state_d     = LOAD;
                end else begin
                    state_d = state_q;
                end
                if (sol_valid) begin
                    rows_d[0] = sol_row;
                    cnt_d     = 4'd1;
                    state_d   = RECV;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RECV: begin
                if (sol_valid) begin
                    rows_d[cnt_q] = sol_row;
                    if (cnt_q == MAX_IDX) begin
                        state_d = CHECK;
                        k_d     = 4'd0;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            CHECK: begin
                if (col_fail) begin
                    state_d    = REPORT;
                    done_d     = 1'b1;
                    err_code_d = col_code;
                    err_col_d  = k_q;
                end else if (k_q == MAX_IDX) begin
                    state_d = REPORT;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            REPORT: begin
                state_d = IDLE;
                mask_d  = {N{1'b0}};
                cnt_d   = 4'd0;
                k_d     = 4'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, storage and registered verdict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            k_q        <= 4'd0;
            mask_q     <= {N{1'b0}};
            pre_q      <= '0;
            rows_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_code_q <= ERR_OK;
            err_col_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            mask_q     <= mask_d;
            pre_q      <= pre_d;
            rows_q     <= rows_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_code_q <= err_code_d;
            err_col_q  <= err_col_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign err_code = err_code_q;
    assign err_col  = err_col_q;

endmodule

// File: doc/queen_check.md
QUEEN_CHECK -- requirements
Module: queen_check

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rst_n, input, 1, reset; rst_n is asynchronous and active-low, and clock is clk.
REQ-003 SHALL have in_valid, input, 1, a pre-placed queen beat is present.
REQ-004 SHALL have col and row, input, 4 each, the pre-placed queen column and row, sampled when in_valid=1.
REQ-005 SHALL have sol_valid, input, 1, a solution beat is present (solver out_valid).
REQ-006 SHALL have sol_row, input, 4, the solution row for the next column in order 0..11 (solver out).
REQ-007 SHALL have done, output, 1, a one-cycle verdict strobe.
REQ-008 SHALL have pass, output, 1, the solution is legal; valid only while done=1.
REQ-009 SHALL have err_code, output, 2: 00 ok, 01 row out of range, 10 pre-placed mismatch, 11 attack; valid only while done=1.
REQ-010 SHALL have err_col, output, 4, the first failing column, 0 when passing; valid only while done=1.

Function
REQ-011 SHALL implement states IDLE, LOAD, RECV, CHECK, REPORT.
REQ-012 In IDLE, the first in_valid beat SHALL clear the pre-placed mask, record row at index col, set mask[col], and go to LOAD.
REQ-013 In LOAD, each further in_valid beat SHALL record a pre-placed queen; a repeated col overwrites the earlier one (last beat wins).
REQ-014 A beat with col>11 SHALL be ignored.
REQ-015 In IDLE or LOAD, sol_valid=1 SHALL store sol_row as column 0 and go to RECV; an empty mask is legal.
REQ-016 In RECV, each sol_valid beat SHALL store the next column; gaps in sol_valid are allowed.
REQ-017 After the 12th beat (column 11), the block SHALL go to CHECK with column index k=0.
REQ-018 In CHECK, each cycle SHALL examine column k only, with this priority:
  - row[k]>11 gives 01;
  - mask[k] and row[k] differ from the pre-placed row gives 10;
  - any i<k with row[i]==row[k] or |row[i]-row[k]|==k-i gives 11.
REQ-019 Differences in REQ-018 SHALL be computed as 4-bit unsigned magnitudes with no wrap (larger minus smaller).
REQ-020 On the first failing k, the block SHALL latch the code and k and go to REPORT; otherwise k increments, and after k=11 it goes to REPORT with pass.
REQ-021 Pass latency: done SHALL assert exactly 13 cycles after the cycle that accepted the 12th solution beat.
REQ-022 Fail latency: done SHALL assert k+2 cycles after that cycle.
REQ-023 REPORT SHALL last one cycle, driving done=1 and the verdict, then return to IDLE.
REQ-024 done, pass, err_code and err_col SHALL be 0 in every cycle other than REPORT.
REQ-025 in_valid and sol_valid SHALL be ignored during CHECK and REPORT.
REQ-026 in_valid during RECV SHALL be ignored.
REQ-027 If in_valid and sol_valid are both high in IDLE or LOAD, the pre-placed beat SHALL be recorded first, then the solution beat stored in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately set state=IDLE, clear the mask, the beat counter and k, and zero done, pass, err_code and err_col.
REQ-029 Reset mid-RECV or mid-CHECK SHALL abandon the job with no done pulse.

Structure
REQ-030 A shared package queen_pkg SHALL hold N=12, the state enum and the err_code constants, shared with the solver.
REQ-031 One sub-module queen_col_check SHALL be used: combinational, taking the 12-entry row array, k, mask and pre-placed row, and returning fail and code.

Verification
REQ-032 The bench SHALL cover these scenarios:
  - No pre-place; sol rows 1,3,5,7,9,11,0,2,4,6,8,10 -> done 13 cycles after the last beat, pass=1, err_code=00, err_col=0.
  - Pre-place (3,7); same solution -> pass=1.
  - Pre-place (3,0); same solution -> pass=0, err_code=10, err_col=3.
  - Sol rows 0,1,2,...,11 -> err_code=11, err_col=1, done 3 cycles after the last beat.
  - Valid solution with column 5 row 13 -> err_code=01, err_col=5.
  - rst_n pulsed after 6 beats, then a full valid stream -> no done before it, then pass=1.
